// File: rtl/cenn_window_gen.sv
// cenn_window_gen: raster pixel stream in, one 3x3 CeNN u-window per pixel out, built from two circular line buffers.
// Optional macro CENN_PAD_REPLICATE_EN: out-of-image taps replicate the nearest edge pixel instead of using BOUND.
module cenn_window_gen #(
   parameter int               width = 15,
   parameter int               IMG_W = 64,
   parameter int               IMG_H = 64,
   parameter logic [width-1:0] BOUND = 15'b111111000000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_valid,
   input  logic             sof,
   input  logic [width-1:0] pix_in,
   output logic             pix_ready,
   output logic [width-1:0] u11,
   output logic [width-1:0] u12,
   output logic [width-1:0] u13,
   output logic [width-1:0] u21,
   output logic [width-1:0] u22,
   output logic [width-1:0] u23,
   output logic [width-1:0] u31,
   output logic [width-1:0] u32,
   output logic [width-1:0] u33,
   output logic             ready_signal,
   output logic             eof
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

   state_t                    state;
   logic [CW-1:0]             in_col, out_c, lb_idx;
   logic [RW-1:0]             in_row, out_r;
   logic [width-1:0]          lb0 [IMG_W];
   logic [width-1:0]          lb1 [IMG_W];
   logic [width-1:0]          pix_w;
   logic [2:0][width-1:0]     col_a, col_b, col_n;
   logic [2:0][2:0][width-1:0] win, tap;
   logic [2:0]                row_oob, col_oob;
   logic accept, restart, load, adv, emit;
   logic win_start, last_pix, last_win;

   assign accept    = pix_valid && pix_ready;
   assign restart   = accept && sof;
   assign load      = restart || (accept && (state == FILL || state == STREAM));
   assign adv       = load || (state == FLUSH);
   assign lb_idx    = restart ? '0 : in_col;
   assign win_start = (in_row == RW'(1)) && (in_col == CW'(1));
   assign last_pix  = (in_row == LAST_R) && (in_col == LAST_C);
   assign last_win  = (out_r == LAST_R) && (out_c == LAST_C);
   assign emit      = !restart && ((state == FILL && accept && win_start) ||
                                   (state == STREAM && accept) ||
                                   (state == FLUSH));

   // During FLUSH the bottom row of each new column is below the image, so its value is never used.
   assign pix_w = (state == FLUSH) ? '0 : pix_in;
   assign col_n = {pix_w, lb0[lb_idx], lb1[lb_idx]};

   always_comb begin
      win = '0;
      for (int r = 0; r < 3; r++) begin
         win[r] = {col_n[r], col_b[r], col_a[r]};
      end
   end

   // Padding is decided from the output centre position only; buffer contents are never inspected.
   assign row_oob = {out_r == LAST_R, 1'b0, out_r == '0};
   assign col_oob = {out_c == LAST_C, 1'b0, out_c == '0};

   always_comb begin
      tap = '0;
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
`ifdef CENN_PAD_REPLICATE_EN
            tap[dr][dc] = win[row_oob[dr] ? 2'd1 : 2'(dr)][col_oob[dc] ? 2'd1 : 2'(dc)];
`else
            tap[dr][dc] = (row_oob[dr] || col_oob[dc]) ? BOUND : win[dr][dc];
`endif
         end
      end
   end

   // lb0 holds the row above the incoming pixel, lb1 the row above that.
   always_ff @(posedge clk) begin
      if (!rst && adv) begin
         lb1[lb_idx] <= lb0[lb_idx];
         lb0[lb_idx] <= pix_w;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pix_ready    <= 1'b0;
         ready_signal <= 1'b0;
         eof          <= 1'b0;
         in_row       <= '0;
         in_col       <= '0;
         out_r        <= '0;
         out_c        <= '0;
         col_a        <= '0;
         col_b        <= '0;
         u11 <= '0; u12 <= '0; u13 <= '0;
         u21 <= '0; u22 <= '0; u23 <= '0;
         u31 <= '0; u32 <= '0; u33 <= '0;
      end else begin
         ready_signal <= emit;
         eof          <= emit && last_win;
         if (adv) begin
            col_a <= col_b;
            col_b <= col_n;
         end
         if (emit) begin
            u11 <= tap[0][0]; u12 <= tap[0][1]; u13 <= tap[0][2];
            u21 <= tap[1][0]; u22 <= tap[1][1]; u23 <= tap[1][2];
            u31 <= tap[2][0]; u32 <= tap[2][1]; u33 <= tap[2][2];
         end
         if (restart) begin
            in_row <= '0;
            in_col <= CW'(1);
            out_r  <= '0;
            out_c  <= '0;
         end else begin
            if (adv) begin
               in_col <= (in_col == LAST_C) ? '0 : in_col + 1'b1;
               if (state != FLUSH && in_col == LAST_C)
                  in_row <= (in_row == LAST_R) ? '0 : in_row + 1'b1;
            end
            if (emit) begin
               out_c <= (out_c == LAST_C) ? '0 : out_c + 1'b1;
               if (out_c == LAST_C)
                  out_r <= (out_r == LAST_R) ? '0 : out_r + 1'b1;
            end
         end
         case (state)
            IDLE: begin
               pix_ready <= 1'b1;
               if (restart) state <= FILL;
            end
            FILL: begin
               if (accept && !restart && win_start) state <= STREAM;
            end
            STREAM: begin
               if (restart) begin
                  state <= FILL;
               end else if (accept && last_pix) begin
                  state     <= FLUSH;
                  pix_ready <= 1'b0;
               end
            end
            FLUSH: begin
               if (last_win) begin
                  state     <= IDLE;
                  pix_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
